// File: rtl/iob_axi_ram_responder_pkg.sv
// iob_axi_ram_responder shared types and constants.
// FSM encoding and AXI response codes.
package iob_axi_ram_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_DATA = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/iob_axi_ram_responder_if.sv
// AXI4 bus bundle between an external-memory master
// and the RAM responder.
interface iob_axi_ram_responder_if #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 4,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
);
  localparam int STRB_W = AXI_DATA_W / 8;

  logic [AXI_ID_W-1:0]   axi_awid_i;
  logic [AXI_ADDR_W-1:0] axi_awaddr_i;
  logic [AXI_LEN_W-1:0]  axi_awlen_i;
  logic [2:0]            axi_awsize_i;
  logic [1:0]            axi_awburst_i;
  logic                  axi_awlock_i;
  logic [3:0]            axi_awcache_i;
  logic [2:0]            axi_awprot_i;
  logic                  axi_awvalid_i;
  logic                  axi_awready_o;

  logic [AXI_DATA_W-1:0] axi_wdata_i;
  logic [STRB_W-1:0]     axi_wstrb_i;
  logic                  axi_wlast_i;
  logic                  axi_wvalid_i;
  logic                  axi_wready_o;

  logic [AXI_ID_W-1:0]   axi_bid_o;
  logic [1:0]            axi_bresp_o;
  logic                  axi_bvalid_o;
  logic                  axi_bready_i;

  logic [AXI_ID_W-1:0]   axi_arid_i;
  logic [AXI_ADDR_W-1:0] axi_araddr_i;
  logic [AXI_LEN_W-1:0]  axi_arlen_i;
  logic [2:0]            axi_arsize_i;
  logic [1:0]            axi_arburst_i;
  logic                  axi_arlock_i;
  logic [3:0]            axi_arcache_i;
  logic [2:0]            axi_arprot_i;
  logic                  axi_arvalid_i;
  logic                  axi_arready_o;

  logic [AXI_ID_W-1:0]   axi_rid_o;
  logic [AXI_DATA_W-1:0] axi_rdata_o;
  logic [1:0]            axi_rresp_o;
  logic                  axi_rlast_o;
  logic                  axi_rvalid_o;
  logic                  axi_rready_i;

  modport master (
    output axi_awid_i, axi_awaddr_i, axi_awlen_i,
    output axi_awsize_i, axi_awburst_i, axi_awlock_i,
    output axi_awcache_i, axi_awprot_i, axi_awvalid_i,
    input  axi_awready_o,
    output axi_wdata_i, axi_wstrb_i, axi_wlast_i,
    output axi_wvalid_i,
    input  axi_wready_o,
    input  axi_bid_o, axi_bresp_o, axi_bvalid_o,
    output axi_bready_i,
    output axi_arid_i, axi_araddr_i, axi_arlen_i,
    output axi_arsize_i, axi_arburst_i, axi_arlock_i,
    output axi_arcache_i, axi_arprot_i, axi_arvalid_i,
    input  axi_arready_o,
    input  axi_rid_o, axi_rdata_o, axi_rresp_o,
    input  axi_rlast_o, axi_rvalid_o,
    output axi_rready_i
  );

  modport slave (
    input  axi_awid_i, axi_awaddr_i, axi_awlen_i,
    input  axi_awsize_i, axi_awburst_i, axi_awlock_i,
    input  axi_awcache_i, axi_awprot_i, axi_awvalid_i,
    output axi_awready_o,
    input  axi_wdata_i, axi_wstrb_i, axi_wlast_i,
    input  axi_wvalid_i,
    output axi_wready_o,
    output axi_bid_o, axi_bresp_o, axi_bvalid_o,
    input  axi_bready_i,
    input  axi_arid_i, axi_araddr_i, axi_arlen_i,
    input  axi_arsize_i, axi_arburst_i, axi_arlock_i,
    input  axi_arcache_i, axi_arprot_i, axi_arvalid_i,
    output axi_arready_o,
    output axi_rid_o, axi_rdata_o, axi_rresp_o,
    output axi_rlast_o, axi_rvalid_o,
    input  axi_rready_i
  );

endinterface

// File: rtl/iob_ram_sp_be.sv
// Single-port synchronous RAM, byte write enables,
// registered read port that holds while disabled.
module iob_ram_sp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                en_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   d_i,
  output logic [DATA_W-1:0]   d_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < NB; i++) begin
        if (we_i[i]) mem[addr_i][i*8 +: 8] <= d_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      d_o <= '0;
    end else if (en_i && (we_i == '0)) begin
      d_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/iob_axi_ram_responder.sv
// AXI4 slave backed by on-chip RAM; serves one INCR
// burst at a time, alternating AW/AR under contention.
module iob_axi_ram_responder
  import iob_axi_ram_responder_pkg::*;
#(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 4,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int MEM_ADDR_W = 14
) (
  input logic clk_i,
  input logic arst_n_i,
  iob_axi_ram_responder_if.slave axi
);
  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int B      = $clog2(STRB_W);

  state_t                state;
  logic                  last_rd;
  logic [AXI_ID_W-1:0]   id_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [AXI_LEN_W-1:0]  len_q;
  logic [AXI_LEN_W-1:0]  cnt_q;
  logic [AXI_LEN_W-1:0]  cnt_nxt;
  logic                  bvalid_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [AXI_ID_W-1:0]   bid_q;
  logic [AXI_ID_W-1:0]   rid_q;

  logic                  idle;
  logic                  grant_w;
  logic                  grant_r;
  logic                  w_hs;
  logic                  r_hs;
  logic                  ram_en;
  logic [STRB_W-1:0]     ram_we;
  logic [MEM_ADDR_W-1:0] aw_word;
  logic [MEM_ADDR_W-1:0] ar_word;
  logic [AXI_DATA_W-1:0] ram_q;

  // Readies are gated by reset so nothing is granted while held.
  assign idle    = (state == ST_IDLE) & arst_n_i;
  assign grant_w = idle & axi.axi_awvalid_i
                 & (~axi.axi_arvalid_i | last_rd);
  assign grant_r = idle & axi.axi_arvalid_i
                 & (~axi.axi_awvalid_i | ~last_rd);

  assign aw_word = axi.axi_awaddr_i[MEM_ADDR_W+B-1:B];
  assign ar_word = axi.axi_araddr_i[MEM_ADDR_W+B-1:B];

  assign w_hs    = (state == ST_WR_DATA) & axi.axi_wvalid_i;
  assign r_hs    = rvalid_q & axi.axi_rready_i;
  assign cnt_nxt = cnt_q + 1'b1;

  assign ram_en = w_hs | (state == ST_RD_ADDR)
                | (r_hs & ~rlast_q);
  assign ram_we = w_hs ? axi.axi_wstrb_i : '0;

  assign axi.axi_awready_o = grant_w;
  assign axi.axi_arready_o = grant_r;
  assign axi.axi_wready_o  = (state == ST_WR_DATA);
  assign axi.axi_bvalid_o  = bvalid_q;
  assign axi.axi_bid_o     = bid_q;
  assign axi.axi_bresp_o   = RESP_OKAY;
  assign axi.axi_rvalid_o  = rvalid_q;
  assign axi.axi_rlast_o   = rlast_q;
  assign axi.axi_rid_o     = rid_q;
  assign axi.axi_rresp_o   = RESP_OKAY;
  assign axi.axi_rdata_o   = ram_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state    <= ST_IDLE;
      last_rd  <= 1'b1;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      bid_q    <= '0;
      rid_q    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant_w) begin
            id_q    <= axi.axi_awid_i;
            addr_q  <= aw_word;
            len_q   <= axi.axi_awlen_i;
            cnt_q   <= '0;
            last_rd <= 1'b0;
            state   <= ST_WR_DATA;
          end else if (grant_r) begin
            id_q    <= axi.axi_arid_i;
            addr_q  <= ar_word;
            len_q   <= axi.axi_arlen_i;
            cnt_q   <= '0;
            last_rd <= 1'b1;
            state   <= ST_RD_ADDR;
          end
        end
        ST_WR_DATA: begin
          if (w_hs) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_nxt;
            if (cnt_q == len_q) begin
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              state    <= ST_WR_RESP;
            end
          end
        end
        ST_WR_RESP: begin
          if (axi.axi_bready_i) begin
            bvalid_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          // addr_q runs one word ahead of the beat on the bus
          addr_q   <= addr_q + 1'b1;
          rvalid_q <= 1'b1;
          rid_q    <= id_q;
          rlast_q  <= (len_q == '0);
          state    <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              cnt_q   <= cnt_nxt;
              rlast_q <= (cnt_nxt == len_q);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  iob_ram_sp_be #(
    .DATA_W (AXI_DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .en_i     (ram_en),
    .we_i     (ram_we),
    .addr_i   (addr_q),
    .d_i      (axi.axi_wdata_i),
    .d_o      (ram_q)
  );

  logic unused_sig;
  assign unused_sig = ^{axi.axi_awaddr_i, axi.axi_araddr_i,
    axi.axi_awsize_i, axi.axi_awburst_i, axi.axi_awlock_i,
    axi.axi_awcache_i, axi.axi_awprot_i, axi.axi_arsize_i,
    axi.axi_arburst_i, axi.axi_arlock_i, axi.axi_arcache_i,
    axi.axi_arprot_i, axi.axi_wlast_i};

endmodule
